dmem_responder: RTL and testbench
=================================

# dmem_responder

Cycle-accurate data-memory responder for the datapath's dmem request/response interface: the far end of the load/store port that the execute stage drives. It accepts one request per cycle, commits stores and LR/SC in a private 64-bit-word array, and returns load data, tags, nacks and misaligned/page-fault exceptions with fixed timing. It serves as the dcache stand-in in core-level simulation and as a small on-chip scratchpad.

## Interface
- DEPTH, 1024: number of 64-bit words; power of two.
- ADDR_W, 40: request address width (matches addr_t).
- clk_i  in  1  clock; all state updates on the rising edge.
- rstn_i  in  1  asynchronous active-low reset.
- dmem_req_valid_i  in  1  request present.
- dmem_req_cmd_i  in  5  5'b00000 load, 5'b00001 store, 5'b00110 LR, 5'b00111 SC; any other value is treated as load.
- dmem_req_addr_i  in  ADDR_W  byte address.
- dmem_op_type_i  in  64  only [2:0] are used: [1:0] size (0 B, 1 H, 2 W, 3 D), [2] unsigned load.
- dmem_req_data_i  in  64  store/SC data, right-aligned; sampled with the request.
- dmem_req_tag_i  in  8  echoed on the response.
- dmem_req_invalidate_lr_i  in  1  clears the reservation.
- dmem_req_kill_i  in  1  kills the request accepted in the previous cycle.
- nack_inject_i  in  1  test hook: the request accepted this cycle is nacked.
- dmem_req_ready_o  out  1  request accepted when valid_i & ready_o.
- dmem_resp_valid_o  out  1  load/LR/SC data valid.
- dmem_resp_data_o  out  64  extended load data, or SC result (0 = success, 1 = fail).
- dmem_resp_tag_o  out  8  tag of the responding request.
- dmem_resp_nack_o  out  1  request rejected; the requester must resend it.
- dmem_resp_replay_o  out  1  reserved; held 0.
- dmem_xcpt_ma_ld_o / ma_st_o / pf_ld_o / pf_st_o  out  1 each  exception flags. LR counts as a load; SC and store count as a store.

## Operation
- Pipeline stages: accept at cycle T (S0), S1 at T+1, response at T+2. At most 2 requests in flight.
- Misaligned (ma): the address is not a multiple of 1<<size. LR/SC with size < 2 also raise ma.
- Page fault (pf): address >= DEPTH*8. If a request is both misaligned and out of range, ma wins and pf is suppressed.
- Word index is addr[3+log2(DEPTH)-1:3]; the byte offset is addr[2:0].
- Load in S1: read the word, shift right by offset*8, then sign- or zero-extend from the access size per [2].
- Store commits at the end of S1 with a byte mask from size and offset. No commit if killed, nacked or excepting.
- LR: behaves as a load and, at the end of S1, sets the reservation {valid, word index}.
- SC: succeeds if the reservation is valid and matches the word index. On success it writes and returns 0; on failure it returns 1 with no write. Any SC reaching S1 clears the reservation.
- The reservation is also cleared by invalidate_lr_i (any cycle) and by a store to the reserved word.
- Kill: kill_i high at T+1 cancels the request. Nothing is committed and no response, nack or exception is produced at T+2.
- Nack: a request accepted with nack_inject_i=1 produces nack_o=1 and tag at T+2, with resp_valid=0, no commit and no exception. It does not alter the reservation.
- Stores produce no resp_valid. Their exceptions are flagged at T+2.
- Exceptions at T+2 have resp_valid=0, and tag_o is still driven.

## Timing
- Reset: every output is 0, including ready_o. The pipeline, reservation and hazard flag are cleared. Array contents are undefined.
- ready_o = 1 from the first edge after reset release, except:
  - ready_o = 0 in the cycle immediately after a store or SC is accepted, so write and read never collide.
- Load-use: a load accepted at T+2 after a store accepted at T sees the stored data.
- Response outputs are registered and are single-cycle pulses. data_o and tag_o are don't-care when no flag is set.
- invalidate_lr_i coincident with an LR in S1: the invalidate wins and the reservation ends cleared.
- Reset asserted mid-operation: in-flight requests are dropped and no response is produced. A store already past S1 stays committed.

## Test plan
- Store D 0x1122334455667788 @0x40, then LB @0x43 -> at T+2: resp_valid=1, data=0x0000000000000055, tag echoed. LB @0x47 with a byte ≥ 0x80 -> sign-extended.
- Store then immediately a second request -> ready_o=0 for exactly one cycle. A subsequent load returns the new data.
- LR @0x80 then SC @0x80 -> SC data=0. Repeat the SC -> data=1, no write. LR, invalidate_lr_i, SC -> data=1.
- LW @0x42 -> ma_ld=1, resp_valid=0. SD @DEPTH*8 -> pf_st=1, memory unchanged. SH @(DEPTH*8+1) -> ma_st only.
- Store accepted, kill_i at T+1 -> no write, and no flags at T+2.
- nack_inject on a load with tag 0x5A -> nack=1, tag=0x5A, resp_valid=0 at T+2. A back-to-back second load completes normally at T+3.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Request/response bundle between a load/store requester and the data-memory responder.
// Ports: req_* (valid, cmd, addr, op_type, data, tag, invalidate_lr, kill) and nack_inject
// flow requester->responder; req_ready, resp_* and xcpt_* flow back.
interface dmem_responder_if #(
    parameter int ADDR_W = 40
);
    // requester -> responder
    logic              req_valid;
    logic [4:0]        req_cmd;
    logic [ADDR_W-1:0] req_addr;
    logic [63:0]       op_type;
    logic [63:0]       req_data;
    logic [7:0]        req_tag;
    logic              req_invalidate_lr;
    logic              req_kill;
    logic              nack_inject;
    // responder -> requester
    logic              req_ready;
    logic              resp_valid;
    logic [63:0]       resp_data;
    logic [7:0]        resp_tag;
    logic              resp_nack;
    logic              resp_replay;
    logic              xcpt_ma_ld;
    logic              xcpt_ma_st;
    logic              xcpt_pf_ld;
    logic              xcpt_pf_st;

    modport master (
        output req_valid, req_cmd, req_addr, op_type, req_data, req_tag,
               req_invalidate_lr, req_kill, nack_inject,
        input  req_ready, resp_valid, resp_data, resp_tag, resp_nack, resp_replay,
               xcpt_ma_ld, xcpt_ma_st, xcpt_pf_ld, xcpt_pf_st
    );

    modport slave (
        input  req_valid, req_cmd, req_addr, op_type, req_data, req_tag,
               req_invalidate_lr, req_kill, nack_inject,
        output req_ready, resp_valid, resp_data, resp_tag, resp_nack, resp_replay,
               xcpt_ma_ld, xcpt_ma_st, xcpt_pf_ld, xcpt_pf_st
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: 64-bit-word scratchpad serving loads, stores, LR and SC.
// Latency: request accepted at T, evaluated in S1 at T+1, registered response at T+2.
// Backpressure: req_ready drops for exactly one cycle after a store or SC is accepted.
//
// Ports: clk_i, rstn_i (async active-low); dmem (slave modport of dmem_responder_if)
// carrying the request, kill/invalidate/nack-inject controls, ready, response and
// exception flags.
module dmem_responder #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 40
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    dmem_responder_if.slave dmem
);
    localparam int IDX_W = $clog2(DEPTH);
    // First byte address past the array; anything at or above it page-faults.
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(DEPTH) << 3;

    typedef enum logic [1:0] {
        K_LOAD  = 2'd0,
        K_STORE = 2'd1,
        K_LR    = 2'd2,
        K_SC    = 2'd3
    } kind_e;

    typedef struct packed {
        logic              vld;
        kind_e             kind;
        logic [ADDR_W-1:0] addr;
        logic [1:0]        size;
        logic              uns;
        logic [63:0]       data;
        logic [7:0]        tag;
        logic              nack;
    } s1_t;

    function automatic kind_e decode_cmd(input logic [4:0] cmd);
        kind_e k;
        case (cmd)
            5'b00001: k = K_STORE;
            5'b00110: k = K_LR;
            5'b00111: k = K_SC;
            default:  k = K_LOAD;   // unknown commands behave as plain loads
        endcase
        return k;
    endfunction

    // ---------------------------------------------------------------- state
    logic [63:0]      mem_q [DEPTH];
    s1_t              s1_q, s1_d;
    logic             ready_q, ready_d;
    logic             res_vld_q, res_vld_d;
    logic [IDX_W-1:0] res_idx_q, res_idx_d;

    logic             resp_vld_q, resp_vld_d;
    logic [63:0]      resp_dat_q, resp_dat_d;
    logic [7:0]       resp_tag_q, resp_tag_d;
    logic             resp_nack_q, resp_nack_d;
    logic             ma_ld_q, ma_ld_d;
    logic             ma_st_q, ma_st_d;
    logic             pf_ld_q, pf_ld_d;
    logic             pf_st_q, pf_st_d;

    // Only the low three bits of op_type carry meaning.
    logic unused_op_bits;
    assign unused_op_bits = ^dmem.op_type[63:3];

    // ---------------------------------------------------------------- S0: accept
    logic  accept;
    kind_e in_kind;

    assign accept  = dmem.req_valid & ready_q;
    assign in_kind = decode_cmd(dmem.req_cmd);

    always_comb begin
        s1_d      = '0;
        s1_d.vld  = accept;
        s1_d.kind = in_kind;
        s1_d.addr = dmem.req_addr;
        s1_d.size = dmem.op_type[1:0];
        s1_d.uns  = dmem.op_type[2];
        s1_d.data = dmem.req_data;
        s1_d.tag  = dmem.req_tag;
        s1_d.nack = dmem.nack_inject;
    end

    // A write lands at the end of S1; blocking the slot behind it keeps a
    // read from ever being evaluated in the same cycle as a commit.
    assign ready_d = ~(accept & ((in_kind == K_STORE) | (in_kind == K_SC)));

    // ---------------------------------------------------------------- S1: evaluate
    logic             live;       // in S1 and not killed
    logic             act;        // live and not nacked: allowed to take effect
    logic [2:0]       off;
    logic [IDX_W-1:0] idx;
    logic [2:0]       align_mask;
    logic [7:0]       size_bytes;
    logic [7:0]       byte_en;
    logic             is_st;
    logic             is_atomic;
    logic             ma;
    logic             pf;
    logic             xcpt;
    logic             sc_ok;
    logic             do_write;
    logic [63:0]      rd_word;
    logic [63:0]      shifted;
    logic [63:0]      ld_ext;
    logic [63:0]      wr_data;
    logic             sgn;

    assign live      = s1_q.vld & ~dmem.req_kill;
    assign act       = live & ~s1_q.nack;
    assign off       = s1_q.addr[2:0];
    assign idx       = s1_q.addr[3 +: IDX_W];
    assign is_st     = (s1_q.kind == K_STORE) | (s1_q.kind == K_SC);
    assign is_atomic = (s1_q.kind == K_LR) | (s1_q.kind == K_SC);

    always_comb begin
        align_mask = 3'b000;
        size_bytes = 8'h01;
        case (s1_q.size)
            2'd0: begin align_mask = 3'b000; size_bytes = 8'h01; end
            2'd1: begin align_mask = 3'b001; size_bytes = 8'h03; end
            2'd2: begin align_mask = 3'b011; size_bytes = 8'h0F; end
            default: begin align_mask = 3'b111; size_bytes = 8'hFF; end
        endcase
    end

    // Atomics are only defined on word and doubleword granules.
    assign ma   = (|(off & align_mask)) | (is_atomic & ~s1_q.size[1]);
    // Misalignment takes priority; an out-of-range misaligned access reports ma only.
    assign pf   = ~ma & (s1_q.addr >= ADDR_LIMIT);
    assign xcpt = ma | pf;

    assign sc_ok = res_vld_q & (res_idx_q == idx);

    assign rd_word = mem_q[idx];
    assign shifted = rd_word >> {off, 3'b000};
    assign sgn     = ~s1_q.uns;

    always_comb begin
        ld_ext = shifted;
        case (s1_q.size)
            2'd0: ld_ext = {{56{sgn & shifted[7]}},  shifted[7:0]};
            2'd1: ld_ext = {{48{sgn & shifted[15]}}, shifted[15:0]};
            2'd2: ld_ext = {{32{sgn & shifted[31]}}, shifted[31:0]};
            default: ld_ext = shifted;
        endcase
    end

    assign byte_en  = size_bytes << off;
    assign wr_data  = s1_q.data << {off, 3'b000};
    assign do_write = act & ~xcpt &
                      ((s1_q.kind == K_STORE) | ((s1_q.kind == K_SC) & sc_ok));

    // ---------------------------------------------------------------- reservation
    always_comb begin
        res_vld_d = res_vld_q;
        res_idx_d = res_idx_q;
        if (act) begin
            if ((s1_q.kind == K_LR) & ~xcpt) begin
                res_vld_d = 1'b1;
                res_idx_d = idx;
            end
            // Every SC consumes the reservation, pass or fail.
            if (s1_q.kind == K_SC) begin
                res_vld_d = 1'b0;
            end
            if ((s1_q.kind == K_STORE) & ~xcpt & (res_idx_q == idx)) begin
                res_vld_d = 1'b0;
            end
        end
        // Applied last so it beats an LR setting the reservation in the same cycle.
        if (dmem.req_invalidate_lr) begin
            res_vld_d = 1'b0;
        end
    end

    // ---------------------------------------------------------------- response
    always_comb begin
        resp_vld_d  = act & ~xcpt & ~(s1_q.kind == K_STORE);
        resp_dat_d  = '0;
        if (resp_vld_d) begin
            resp_dat_d = (s1_q.kind == K_SC) ? {63'd0, ~sc_ok} : ld_ext;
        end
        resp_tag_d  = live ? s1_q.tag : 8'h00;
        resp_nack_d = live & s1_q.nack;
        ma_ld_d     = act & ma & ~is_st;
        ma_st_d     = act & ma &  is_st;
        pf_ld_d     = act & pf & ~is_st;
        pf_st_d     = act & pf &  is_st;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            s1_q        <= '0;
            ready_q     <= 1'b0;
            res_vld_q   <= 1'b0;
            res_idx_q   <= '0;
            resp_vld_q  <= 1'b0;
            resp_dat_q  <= '0;
            resp_tag_q  <= '0;
            resp_nack_q <= 1'b0;
            ma_ld_q     <= 1'b0;
            ma_st_q     <= 1'b0;
            pf_ld_q     <= 1'b0;
            pf_st_q     <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            ready_q     <= ready_d;
            res_vld_q   <= res_vld_d;
            res_idx_q   <= res_idx_d;
            resp_vld_q  <= resp_vld_d;
            resp_dat_q  <= resp_dat_d;
            resp_tag_q  <= resp_tag_d;
            resp_nack_q <= resp_nack_d;
            ma_ld_q     <= ma_ld_d;
            ma_st_q     <= ma_st_d;
            pf_ld_q     <= pf_ld_d;
            pf_st_q     <= pf_st_d;
        end
    end

    // Array contents survive reset; a reset in flight clears s1_q first, so no
    // partially accepted store can commit.
    always_ff @(posedge clk_i) begin
        if (do_write) begin
            for (int b = 0; b < 8; b++) begin
                if (byte_en[b]) begin
                    mem_q[idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    assign dmem.req_ready   = ready_q;
    assign dmem.resp_valid  = resp_vld_q;
    assign dmem.resp_data   = resp_dat_q;
    assign dmem.resp_tag    = resp_tag_q;
    assign dmem.resp_nack   = resp_nack_q;
    assign dmem.resp_replay = 1'b0;
    assign dmem.xcpt_ma_ld  = ma_ld_q;
    assign dmem.xcpt_ma_st  = ma_st_q;
    assign dmem.xcpt_pf_ld  = pf_ld_q;
    assign dmem.xcpt_pf_st  = pf_st_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: scenario tasks drive requests and push expected
// responses to a scoreboard; a negedge monitor pops and compares each response.
module tb_dmem_responder;
    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 40;

    localparam logic [4:0] C_LD = 5'b00000;
    localparam logic [4:0] C_ST = 5'b00001;
    localparam logic [4:0] C_LR = 5'b00110;
    localparam logic [4:0] C_SC = 5'b00111;
    localparam logic [2:0] OP_B = 3'b000, OP_H = 3'b001, OP_W = 3'b010, OP_D = 3'b011;
    localparam logic [2:0] OP_BU = 3'b100, OP_WU = 3'b110;

    logic clk_i;
    logic rstn_i;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    dmem_responder_if #(.ADDR_W(ADDR_W)) dmem ();

    dmem_responder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .dmem   (dmem)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic        vld;
        logic [63:0] data;
        logic [7:0]  tag;
        logic        nack;
        logic [3:0]  xc;     // {ma_ld, ma_st, pf_ld, pf_st}
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic mon_any;
    logic [3:0] mon_xc;

    // Response checker: every flagged output must match the oldest expectation
    // in the cycle it was due; expectations left past their cycle are misses.
    always @(negedge clk_i) begin
        mon_xc  = {dmem.xcpt_ma_ld, dmem.xcpt_ma_st, dmem.xcpt_pf_ld, dmem.xcpt_pf_st};
        mon_any = dmem.resp_valid | dmem.resp_nack | (|mon_xc);
        if (sb.size() != 0 && sb[0].due < cyc) begin
            total++; bad++;
            $display("FAIL missing_resp: tag=%02h due cyc %0d, nothing seen by cyc %0d", sb[0].tag, sb[0].due, cyc);
            void'(sb.pop_front());
        end
        if (mon_any) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_resp: cyc=%0d vld=%0b nack=%0b xc=%b tag=%02h, want no response", cyc, dmem.resp_valid, dmem.resp_nack, mon_xc, dmem.resp_tag);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.due !== cyc || mon_e.vld !== dmem.resp_valid || mon_e.nack !== dmem.resp_nack ||
                    mon_e.xc !== mon_xc || mon_e.tag !== dmem.resp_tag ||
                    (mon_e.vld && mon_e.data !== dmem.resp_data)) begin
                    bad++;
                    $display("FAIL resp_tag_%02h: got cyc=%0d vld=%0b nack=%0b xc=%b tag=%02h data=%016h, want cyc=%0d vld=%0b nack=%0b xc=%b tag=%02h data=%016h",
                             mon_e.tag, cyc, dmem.resp_valid, dmem.resp_nack, mon_xc, dmem.resp_tag, dmem.resp_data,
                             mon_e.due, mon_e.vld, mon_e.nack, mon_e.xc, mon_e.tag, mon_e.data);
                end
            end
        end
    end

    // One cycle of stimulus; acc reports whether the request was accepted.
    task automatic drive(input logic v, input logic [4:0] cmd, input logic [ADDR_W-1:0] a,
                         input logic [2:0] op, input logic [63:0] d, input logic [7:0] tag,
                         input logic kill, input logic inv, input logic nk, output logic acc);
        dmem.req_valid         = v;
        dmem.req_cmd           = cmd;
        dmem.req_addr          = a;
        dmem.op_type           = {61'd0, op};
        dmem.req_data          = d;
        dmem.req_tag           = tag;
        dmem.req_kill          = kill;
        dmem.req_invalidate_lr = inv;
        dmem.nack_inject       = nk;
        acc = v & dmem.req_ready;
        @(posedge clk_i);
        #1;
        dmem.req_valid = 1'b0;
    endtask

    task automatic idle(input int n, input logic kill, input logic inv);
        logic acc;
        for (int i = 0; i < n; i++) drive(1'b0, C_LD, '0, OP_D, '0, 8'h00, kill, inv, 1'b0, acc);
    endtask

    // Expectation for a request accepted at the edge just passed.
    task automatic push_exp(input logic v, input logic [63:0] d, input logic [7:0] t,
                            input logic nk, input logic [3:0] xc);
        exp_t e;
        e.due = cyc + 1; e.vld = v; e.data = d; e.tag = t; e.nack = nk; e.xc = xc;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        rstn_i = 1'b0;
        dmem.req_valid = 1'b0; dmem.req_cmd = '0; dmem.req_addr = '0; dmem.op_type = '0;
        dmem.req_data = '0; dmem.req_tag = '0; dmem.req_kill = 1'b0;
        dmem.req_invalidate_lr = 1'b0; dmem.nack_inject = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        total++;
        if ({dmem.req_ready, dmem.resp_valid, dmem.resp_data, dmem.resp_tag, dmem.resp_nack, dmem.resp_replay,
             dmem.xcpt_ma_ld, dmem.xcpt_ma_st, dmem.xcpt_pf_ld, dmem.xcpt_pf_st} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: ready=%0b vld=%0b data=%016h tag=%02h nack=%0b, want all 0",
                     dmem.req_ready, dmem.resp_valid, dmem.resp_data, dmem.resp_tag, dmem.resp_nack);
        end
        rstn_i = 1'b1;
        total++;
        if (dmem.req_ready !== 1'b0) begin bad++; $display("FAIL ready_before_edge: got %0b want 0", dmem.req_ready); end
        idle(1, 1'b0, 1'b0);
        total++;
        if (dmem.req_ready !== 1'b1) begin bad++; $display("FAIL ready_after_reset: got %0b want 1", dmem.req_ready); end
    endtask

    task automatic test_load_extend();
        logic acc;
        drive(1'b1, C_ST, 40'h40, OP_D, 64'h1122334455667788, 8'h01, 1'b0, 1'b0, 1'b0, acc);
        total++;
        if (acc !== 1'b1) begin bad++; $display("FAIL accept_sd: got %0b want 1", acc); end
        idle(1, 1'b0, 1'b0);
        drive(1'b1, C_LD, 40'h43, OP_B,  '0, 8'h02, 1'b0, 1'b0, 1'b0, acc); push_exp(1'b1, 64'h0000000000000055, 8'h02, 1'b0, 4'b0);
        drive(1'b1, C_LD, 40'h40, OP_B,  '0, 8'h03, 1'b0, 1'b0, 1'b0, acc); push_exp(1'b1, 64'hFFFFFFFFFFFFFF88, 8'h03, 1'b0, 4'b0);
        drive(1'b1, C_ST, 40'h47, OP_B,  64'h9A, 8'h04, 1'b0, 1'b0, 1'b0, acc);
        idle(1, 1'b0, 1'b0);
        drive(1'b1, C_LD, 40'h47, OP_B,  '0, 8'h05, 1'b0, 1'b0, 1'b0, acc); push_exp(1'b1, 64'hFFFFFFFFFFFFFF9A, 8'h05, 1'b0, 4'b0);
        drive(1'b1, C_LD, 40'h47, OP_BU, '0, 8'h06, 1'b0, 1'b0, 1'b0, acc); push_exp(1'b1, 64'h000000000000009A, 8'h06, 1'b0, 4'b0);
        drive(1'b1, C_LD, 40'h46, OP_H,  '0, 8'h07, 1'b0, 1'b0, 1'b0, acc); push_exp(1'b1, 64'hFFFFFFFFFFFF9A22, 8'h07, 1'b0, 4'b0);
        drive(1'b1, C_LD, 40'h44, OP_WU, '0, 8'h08, 1'b0, 1'b0, 1'b0, acc); push_exp(1'b1, 64'h000000009A223344, 8'h08, 1'b0, 4'b0);
        drive(1'b1, C_LD, 40'h40, OP_D,  '0, 8'h09, 1'b0, 1'b0, 1'b0, acc); push_exp(1'b1, 64'h9A22334455667788, 8'h09, 1'b0, 4'b0);
        idle(3, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic acc;
        drive(1'b1, C_ST, 40'h100, OP_W, 64'hDEADBEEF, 8'h20, 1'b0, 1'b0, 1'b0, acc);
        total++;
        if (dmem.req_ready !== 1'b0) begin bad++; $display("FAIL ready_after_store: got %0b want 0", dmem.req_ready); end
        drive(1'b1, C_LD, 40'h100, OP_WU, '0, 8'h2F, 1'b0, 1'b0, 1'b0, acc);
        total++;
        if (acc !== 1'b0) begin bad++; $display("FAIL blocked_accept: got %0b want 0", acc); end
        total++;
        if (dmem.req_ready !== 1'b1) begin bad++; $display("FAIL ready_recovers: got %0b want 1", dmem.req_ready); end
        drive(1'b1, C_LD, 40'h100, OP_WU, '0, 8'h21, 1'b0, 1'b0, 1'b0, acc); push_exp(1'b1, 64'h00000000DEADBEEF, 8'h21, 1'b0, 4'b0);
        total++;
        if (dmem.req_ready !== 1'b1) begin bad++; $display("FAIL ready_after_load: got %0b want 1", dmem.req_ready); end
        idle(3, 1'b0, 1'b0);
    endtask

    task automatic test_lr_sc();
        logic acc;
        drive(1'b1, C_ST, 40'h80, OP_D, 64'hA5A5A5A5A5A5A5A5, 8'h10, 1'b0, 1'b0, 1'b0, acc);
        idle(1, 1'b0, 1'b0);
        drive(1'b1, C_LR, 40'h80, OP_D, '0, 8'h11, 1'b0, 1'b0, 1'b0, acc); push_exp(1'b1, 64'hA5A5A5A5A5A5A5A5, 8'h11, 1'b0, 4'b0);
        drive(1'b1, C_SC, 40'h80, OP_D, 64'h0123456789ABCDEF, 8'h12, 1'b0, 1'b0, 1'b0, acc); push_exp(1'b1, 64'd0, 8'h12, 1'b0, 4'b0);
        idle(1, 1'b0, 1'b0);
        drive(1'b1, C_SC, 40'h80, OP_D, 64'hFFFFFFFFFFFFFFFF, 8'h13, 1'b0, 1'b0, 1'b0, acc); push_exp(1'b1, 64'd1, 8'h13, 1'b0, 4'b0);
        idle(1, 1'b0, 1'b0);
        drive(1'b1, C_LD, 40'h80, OP_D, '0, 8'h14, 1'b0, 1'b0, 1'b0, acc); push_exp(1'b1, 64'h0123456789ABCDEF, 8'h14, 1'b0, 4'b0);
        // invalidate after the LR has settled
        drive(1'b1, C_LR, 40'h80, OP_D, '0, 8'h15, 1'b0, 1'b0, 1'b0, acc); push_exp(1'b1, 64'h0123456789ABCDEF, 8'h15, 1'b0, 4'b0);
        idle(1, 1'b0, 1'b0);
        idle(1, 1'b0, 1'b1);
        drive(1'b1, C_SC, 40'h80, OP_D, 64'h5, 8'h16, 1'b0, 1'b0, 1'b0, acc); push_exp(1'b1, 64'd1, 8'h16, 1'b0, 4'b0);
        idle(1, 1'b0, 1'b0);
        // invalidate coincident with the LR in S1
        drive(1'b1, C_LR, 40'h80, OP_D, '0, 8'h17, 1'b0, 1'b0, 1'b0, acc); push_exp(1'b1, 64'h0123456789ABCDEF, 8'h17, 1'b0, 4'b0);
        idle(1, 1'b0, 1'b1);
        drive(1'b1, C_SC, 40'h80, OP_D, 64'h6, 8'h18, 1'b0, 1'b0, 1'b0, acc); push_exp(1'b1, 64'd1, 8'h18, 1'b0, 4'b0);
        idle(1, 1'b0, 1'b0);
        // a store to the reserved word breaks the reservation
        drive(1'b1, C_LR, 40'h80, OP_D, '0, 8'h19, 1'b0, 1'b0, 1'b0, acc); push_exp(1'b1, 64'h0123456789ABCDEF, 8'h19, 1'b0, 4'b0);
        drive(1'b1, C_ST, 40'h80, OP_D, 64'h0F0F0F0F0F0F0F0F, 8'h1A, 1'b0, 1'b0, 1'b0, acc);
        idle(1, 1'b0, 1'b0);
        drive(1'b1, C_SC, 40'h80, OP_D, 64'hBAD, 8'h1B, 1'b0, 1'b0, 1'b0, acc); push_exp(1'b1, 64'd1, 8'h1B, 1'b0, 4'b0);
        idle(1, 1'b0, 1'b0);
        drive(1'b1, C_LD, 40'h80, OP_D, '0, 8'h1C, 1'b0, 1'b0, 1'b0, acc); push_exp(1'b1, 64'h0F0F0F0F0F0F0F0F, 8'h1C, 1'b0, 4'b0);
        idle(3, 1'b0, 1'b0);
    endtask

    task automatic test_exceptions();
        logic acc;
        drive(1'b1, C_ST, 40'h0, OP_D, 64'h5555555555555555, 8'h40, 1'b0, 1'b0, 1'b0, acc);
        idle(1, 1'b0, 1'b0);
        drive(1'b1, C_ST, 40'h2000, OP_D, 64'hAAAAAAAAAAAAAAAA, 8'h41, 1'b0, 1'b0, 1'b0, acc); push_exp(1'b0, '0, 8'h41, 1'b0, 4'b0001);
        idle(1, 1'b0, 1'b0);
        drive(1'b1, C_LD, 40'h0,    OP_D, '0, 8'h42, 1'b0, 1'b0, 1'b0, acc); push_exp(1'b1, 64'h5555555555555555, 8'h42, 1'b0, 4'b0);
        drive(1'b1, C_LD, 40'h42,   OP_W, '0, 8'h43, 1'b0, 1'b0, 1'b0, acc); push_exp(1'b0, '0, 8'h43, 1'b0, 4'b1000);
        drive(1'b1, C_ST, 40'h2001, OP_H, 64'h1234, 8'h44, 1'b0, 1'b0, 1'b0, acc); push_exp(1'b0, '0, 8'h44, 1'b0, 4'b0100);
        idle(1, 1'b0, 1'b0);
        drive(1'b1, C_LD, 40'h2000, OP_D, '0, 8'h45, 1'b0, 1'b0, 1'b0, acc); push_exp(1'b0, '0, 8'h45, 1'b0, 4'b0010);
        drive(1'b1, C_LR, 40'h80,   OP_B, '0, 8'h46, 1'b0, 1'b0, 1'b0, acc); push_exp(1'b0, '0, 8'h46, 1'b0, 4'b1000);
        drive(1'b1, C_SC, 40'h80,   OP_H, 64'h1, 8'h47, 1'b0, 1'b0, 1'b0, acc); push_exp(1'b0, '0, 8'h47, 1'b0, 4'b0100);
        idle(3, 1'b0, 1'b0);
    endtask

    task automatic test_kill();
        logic acc;
        drive(1'b1, C_ST, 40'hC0, OP_D, 64'h1111111111111111, 8'h30, 1'b0, 1'b0, 1'b0, acc);
        idle(1, 1'b0, 1'b0);
        drive(1'b1, C_ST, 40'hC0, OP_D, 64'h2222222222222222, 8'h31, 1'b0, 1'b0, 1'b0, acc);
        idle(1, 1'b1, 1'b0);
        drive(1'b1, C_LD, 40'hC0, OP_D, '0, 8'h32, 1'b0, 1'b0, 1'b0, acc); push_exp(1'b1, 64'h1111111111111111, 8'h32, 1'b0, 4'b0);
        drive(1'b1, C_LD, 40'hC0, OP_D, '0, 8'h33, 1'b0, 1'b0, 1'b0, acc);
        idle(1, 1'b1, 1'b0);
        drive(1'b1, C_ST, 40'h2000, OP_D, 64'h3, 8'h34, 1'b0, 1'b0, 1'b0, acc);
        idle(1, 1'b1, 1'b0);
        idle(3, 1'b0, 1'b0);
    endtask

    task automatic test_nack();
        logic acc;
        drive(1'b1, C_LD, 40'hC0, OP_D, '0, 8'h5A, 1'b0, 1'b0, 1'b1, acc); push_exp(1'b0, '0, 8'h5A, 1'b1, 4'b0);
        drive(1'b1, C_LD, 40'hC0, OP_D, '0, 8'h5B, 1'b0, 1'b0, 1'b0, acc); push_exp(1'b1, 64'h1111111111111111, 8'h5B, 1'b0, 4'b0);
        drive(1'b1, C_ST, 40'hC0, OP_D, 64'h3333333333333333, 8'h5C, 1'b0, 1'b0, 1'b1, acc); push_exp(1'b0, '0, 8'h5C, 1'b1, 4'b0);
        idle(1, 1'b0, 1'b0);
        drive(1'b1, C_LD, 40'hC0, OP_D, '0, 8'h5D, 1'b0, 1'b0, 1'b0, acc); push_exp(1'b1, 64'h1111111111111111, 8'h5D, 1'b0, 4'b0);
        idle(3, 1'b0, 1'b0);
    endtask

    task automatic test_reset_midflight();
        logic acc;
        drive(1'b1, C_ST, 40'h100, OP_D, 64'hCAFEF00DCAFEF00D, 8'h50, 1'b0, 1'b0, 1'b0, acc);
        idle(2, 1'b0, 1'b0);
        drive(1'b1, C_LD, 40'h100, OP_D, '0, 8'h51, 1'b0, 1'b0, 1'b0, acc);
        rstn_i = 1'b0;
        idle(2, 1'b0, 1'b0);
        rstn_i = 1'b1;
        total++;
        if (dmem.req_ready !== 1'b0) begin bad++; $display("FAIL ready_in_reset: got %0b want 0", dmem.req_ready); end
        idle(1, 1'b0, 1'b0);
        drive(1'b1, C_LD, 40'h100, OP_D, '0, 8'h52, 1'b0, 1'b0, 1'b0, acc); push_exp(1'b1, 64'hCAFEF00DCAFEF00D, 8'h52, 1'b0, 4'b0);
        total++;
        if (acc !== 1'b1) begin bad++; $display("FAIL accept_after_reset: got %0b want 1", acc); end
        idle(3, 1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_load_extend();
        test_back_to_back();
        test_lr_sc();
        test_exceptions();
        test_kill();
        test_nack();
        test_reset_midflight();
        idle(4, 1'b0, 1'b0);
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size()); end
        total++;
        if (dmem.resp_replay !== 1'b0) begin bad++; $display("FAIL replay_low: got %0b want 0", dmem.resp_replay); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
